ccl_scan_dp: RTL

Datapath companion to the collision-check controller in the DCU/CCL path. It stores the four object bytes the controller writes, generates the 4-bit probe position `pos` the controller watches for end-of-sweep, and compares every probe cell against each stored object. It publishes a per-object hit mask and first-hit information when the controller reports ready.

---
 rtl/ccl_pkg.sv | 21 ++
 rtl/ccl_pos_cnt.sv | 23 ++
 rtl/ccl_scan_dp.sv | 107 ++++++++++
 3 files changed

// File: rtl/ccl_pkg.sv
// Shared CCL definitions: probe range, object byte layout and len encodings.
// Imported by the scan datapath and by the collision-check controller.
package ccl_pkg;

  localparam logic [3:0] CCL_POS_LAST = 4'd9;
  localparam int         CCL_NUM_OBJ  = 4;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } ccl_obj_t;

  typedef enum logic [2:0] {
    CCL_LEN_IDLE = 3'd0,
    CCL_LEN_OBJ0 = 3'd1,
    CCL_LEN_OBJ1 = 3'd2,
    CCL_LEN_OBJ2 = 3'd3,
    CCL_LEN_OBJ3 = 3'd4
  } ccl_len_e;

endpackage

// File: rtl/ccl_pos_cnt.sv
// Probe offset counter: counts 0..POS_LAST while enabled, wraps to 0, clears on a new transaction.
// Clear has priority over counting.
module ccl_pos_cnt
  import ccl_pkg::*;
#(
  parameter logic [3:0] POS_LAST = CCL_POS_LAST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       enb,
  output logic [3:0] pos
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      pos <= 4'd0;
    end else if (enb) begin
      pos <= (pos == POS_LAST) ? 4'd0 : pos + 4'd1;
    end
  end

endmodule

// File: rtl/ccl_scan_dp.sv
// Collision scan datapath: object buffer, probe compare, sticky hit mask and done pulse.
// First-hit tracking is built only when CCL_FIRSTHIT_EN is defined; otherwise first_hit_* read 0.
module ccl_scan_dp
  import ccl_pkg::*;
#(
  parameter logic [3:0] POS_LAST = CCL_POS_LAST,
  parameter int         NUM_OBJ  = CCL_NUM_OBJ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wdata,
  input  logic       wenb,
  input  logic [1:0] buf_addr,
  input  logic [2:0] len,
  input  logic       pos_enb,
  input  logic       rdy,
  input  logic [3:0] tx,
  input  logic [3:0] ty,
  output logic [3:0] pos,
  output logic [3:0] hit_mask,
  output logic       hit_any,
  output logic [1:0] first_hit_obj,
  output logic [3:0] first_hit_pos,
  output logic       done
);

  ccl_obj_t   obj_mem [NUM_OBJ];
  logic [3:0] tx_r;
  logic [3:0] ty_r;
  logic       rdy_d;

  logic       new_txn;
  logic       cmp_act;
  logic [1:0] obj_idx;
  logic [3:0] probe_x;
  logic       match;

  assign new_txn = wenb && (buf_addr == 2'd0);
  assign cmp_act = pos_enb && (len >= 3'(CCL_LEN_OBJ0)) && (len <= 3'(CCL_LEN_OBJ3));
  assign obj_idx = 2'(len - 3'd1);
  // 4-bit add wraps, so the probe line is circular in x.
  assign probe_x = tx_r + pos;
  assign match   = cmp_act && (obj_mem[obj_idx] == ccl_obj_t'({ty_r, probe_x}));

  ccl_pos_cnt #(.POS_LAST(POS_LAST)) u_pos_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (new_txn),
    .enb   (pos_enb),
    .pos   (pos)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBJ; i++) obj_mem[i] <= '0;
      tx_r <= 4'd0;
      ty_r <= 4'd0;
    end else begin
      if (wenb) obj_mem[buf_addr] <= ccl_obj_t'(wdata);
      if (new_txn) begin
        tx_r <= tx;
        ty_r <= ty;
      end
    end
  end

  // A byte-0 write clears results even if a match lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n || new_txn) begin
      hit_mask <= 4'd0;
    end else if (match) begin
      hit_mask[obj_idx] <= 1'b1;
    end
  end

  assign hit_any = |hit_mask;

`ifdef CCL_FIRSTHIT_EN
  logic first_seen;

  always_ff @(posedge clk) begin
    if (!rst_n || new_txn) begin
      first_seen    <= 1'b0;
      first_hit_obj <= 2'd0;
      first_hit_pos <= 4'd0;
    end else if (match && !first_seen) begin
      first_seen    <= 1'b1;
      first_hit_obj <= obj_idx;
      first_hit_pos <= pos;
    end
  end
`else
  assign first_hit_obj = 2'd0;
  assign first_hit_pos = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_d <= 1'b0;
      done  <= 1'b0;
    end else begin
      rdy_d <= rdy;
      done  <= rdy && !rdy_d;
    end
  end

endmodule
